// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared state encoding and width helpers for the n-way write-back cache
//
// Contents:
//   state_t    - controller states, INIT first so reset lands in the invalidation sweep
//   byte_off_w - byte-offset bits inside one data word
//   tag_w      - tag bits left once index, word offset and byte offset are removed
package cache_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_LOOKUP,
    ST_HIT,
    ST_WRITEBACK,
    ST_REFILL,
    ST_RESPOND
  } state_t;

  function automatic int byte_off_w(input int word_width);
    return $clog2(word_width / 8);
  endfunction

  function automatic int tag_w(input int adr_width, input int word_width,
                               input int sets, input int words_per_line);
    return adr_width - $clog2(sets) - $clog2(words_per_line) - byte_off_w(word_width);
  endfunction

endpackage

// File: rtl/cache_lru.sv
// rtl/cache_lru.sv - true-LRU age update and victim choice for one set
//
// Ports:
//   ages      in  per-way ages of the set (0 = most recent, WAYS-1 = least recent)
//   valid     in  per-way valid bits of the set
//   acc_way   in  way being accessed this cycle
//   next_ages out ages after acc_way becomes most recent
//   victim    out lowest invalid way, else the way holding the maximum age
module cache_lru #(
  parameter  int WAYS = 4,
  localparam int AW   = $clog2(WAYS)
) (
  input  logic [WAYS-1:0][AW-1:0] ages,
  input  logic [WAYS-1:0]         valid,
  input  logic [AW-1:0]           acc_way,
  output logic [WAYS-1:0][AW-1:0] next_ages,
  output logic [AW-1:0]           victim
);

  logic [AW-1:0] acc_age;
  logic [AW-1:0] max_age;
  logic          have_invalid;

  // Only ways younger than the accessed one age by one; the set stays a permutation.
  always_comb begin
    acc_age   = ages[acc_way];
    next_ages = ages;
    for (int i = 0; i < WAYS; i++) begin
      if (AW'(i) == acc_way) begin
        next_ages[i] = '0;
      end else if (ages[i] < acc_age) begin
        next_ages[i] = ages[i] + AW'(1);
      end
    end
  end

  // The invalid-way scan runs last so it overrides the age-based pick.
  always_comb begin
    victim       = '0;
    max_age      = ages[0];
    have_invalid = 1'b0;
    for (int i = 1; i < WAYS; i++) begin
      if (ages[i] > max_age) begin
        max_age = ages[i];
        victim  = AW'(i);
      end
    end
    for (int i = 0; i < WAYS; i++) begin
      if (!valid[i] && !have_invalid) begin
        have_invalid = 1'b1;
        victim       = AW'(i);
      end
    end
  end

endmodule

// File: rtl/cache_nway_wb.sv
// rtl/cache_nway_wb.sv - n-way set-associative write-back write-allocate cache controller
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset (restarts the INIT sweep)
//   req/rdwr/adr/dat_cpu2cc   CPU request, held until ack_cc2cpu
//   ack_cc2cpu, dat_cc2cpu    one-cycle completion pulse and read data
//   req/rdwr/adr/dat_cc2mem   word-wide memory request (rdwr 1 = write-back)
//   ack_mem2cc, dat_mem2cc    memory word handshake and refill data
//   busy                      high in every state except IDLE
module cache_nway_wb
  import cache_pkg::*;
#(
  parameter int WORD_WIDTH     = 32,
  parameter int ADR_WIDTH      = 32,
  parameter int WAYS           = 4,
  parameter int SETS           = 128,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_cpu2cc,
  input  logic                  rdwr_cpu2cc,
  input  logic [ADR_WIDTH-1:0]  adr_cpu2cc,
  input  logic [WORD_WIDTH-1:0] dat_cpu2cc,
  output logic                  ack_cc2cpu,
  output logic [WORD_WIDTH-1:0] dat_cc2cpu,
  output logic                  req_cc2mem,
  output logic                  rdwr_cc2mem,
  output logic [ADR_WIDTH-1:0]  adr_cc2mem,
  output logic [WORD_WIDTH-1:0] dat_cc2mem,
  input  logic                  ack_mem2cc,
  input  logic [WORD_WIDTH-1:0] dat_mem2cc,
  output logic                  busy
);

  localparam int BYTE_OFF = byte_off_w(WORD_WIDTH);
  localparam int WORD_OFF = $clog2(WORDS_PER_LINE);
  localparam int INDEX_W  = $clog2(SETS);
  localparam int TAG_W    = tag_w(ADR_WIDTH, WORD_WIDTH, SETS, WORDS_PER_LINE);
  localparam int AW       = $clog2(WAYS);
  localparam int DATA_AW  = INDEX_W + AW + WORD_OFF;

  typedef struct packed {
    logic             valid;
    logic             dirty;
    logic [TAG_W-1:0] tag;
  } tag_entry_t;

  tag_entry_t [WAYS-1:0]   tag_mem  [SETS];
  logic [WAYS-1:0][AW-1:0] age_mem  [SETS];
  logic [WORD_WIDTH-1:0]   data_mem [2**DATA_AW];

  state_t               state, state_next;
  logic [INDEX_W-1:0]   sweep;
  logic [WORD_OFF-1:0]  cnt;
  logic [TAG_W-1:0]     req_tag;
  logic [INDEX_W-1:0]   req_idx;
  logic [WORD_OFF-1:0]  req_woff;
  logic                 req_wr;
  logic [AW-1:0]        way_q;

  logic                    hit;
  logic [AW-1:0]           hit_way;
  logic [WAYS-1:0]         set_valid;
  logic [WAYS-1:0][AW-1:0] next_ages;
  logic [WAYS-1:0][AW-1:0] init_ages;
  logic [AW-1:0]           victim;
  tag_entry_t              vic_entry;
  logic                    last_word;
  logic [DATA_AW-1:0]      cpu_word_adr;
  logic [DATA_AW-1:0]      line_word_adr;
  logic                    unused_ok;

  assign unused_ok     = &{1'b0, adr_cpu2cc[BYTE_OFF-1:0]};
  assign last_word     = (cnt == {WORD_OFF{1'b1}});
  assign cpu_word_adr  = {req_idx, way_q, req_woff};
  assign line_word_adr = {req_idx, way_q, cnt};
  assign vic_entry     = tag_mem[req_idx][victim];

  always_comb begin
    init_ages = '0;
    for (int i = 0; i < WAYS; i++) init_ages[i] = AW'(i);
  end

  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    set_valid = '0;
    for (int w = 0; w < WAYS; w++) begin
      set_valid[w] = tag_mem[req_idx][w].valid;
      if (tag_mem[req_idx][w].valid && tag_mem[req_idx][w].tag == req_tag) begin
        hit     = 1'b1;
        hit_way = AW'(w);
      end
    end
  end

  cache_lru #(.WAYS(WAYS)) u_lru (
    .ages      (age_mem[req_idx]),
    .valid     (set_valid),
    .acc_way   (way_q),
    .next_ages (next_ages),
    .victim    (victim)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_INIT;
    else     state <= state_next;
  end

  always_comb begin
    state_next  = state;
    busy        = 1'b1;
    ack_cc2cpu  = 1'b0;
    dat_cc2cpu  = '0;
    req_cc2mem  = 1'b0;
    rdwr_cc2mem = 1'b0;
    adr_cc2mem  = '0;
    dat_cc2mem  = '0;
    case (state)
      ST_INIT: if (sweep == INDEX_W'(SETS - 1)) state_next = ST_IDLE;
      ST_IDLE: begin
        busy = 1'b0;
        if (req_cpu2cc) state_next = ST_LOOKUP;
      end
      ST_LOOKUP: begin
        if (hit)                                     state_next = ST_HIT;
        else if (vic_entry.valid && vic_entry.dirty) state_next = ST_WRITEBACK;
        else                                         state_next = ST_REFILL;
      end
      ST_HIT, ST_RESPOND: begin
        ack_cc2cpu = 1'b1;
        dat_cc2cpu = data_mem[cpu_word_adr];
        state_next = ST_IDLE;
      end
      ST_WRITEBACK: begin
        req_cc2mem  = 1'b1;
        rdwr_cc2mem = 1'b1;
        adr_cc2mem  = {tag_mem[req_idx][way_q].tag, req_idx, cnt, {BYTE_OFF{1'b0}}};
        dat_cc2mem  = data_mem[line_word_adr];
        if (ack_mem2cc && last_word) state_next = ST_REFILL;
      end
      ST_REFILL: begin
        req_cc2mem = 1'b1;
        adr_cc2mem = {req_tag, req_idx, cnt, {BYTE_OFF{1'b0}}};
        if (ack_mem2cc && last_word) state_next = ST_RESPOND;
      end
      default: state_next = ST_INIT;
    endcase
  end

  // cnt wraps to zero on the last word, which readies it for the following phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      sweep <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          tag_mem[sweep] <= '0;
          age_mem[sweep] <= init_ages;
          sweep          <= sweep + INDEX_W'(1);
        end
        ST_IDLE: begin
          if (req_cpu2cc) begin
            req_tag  <= adr_cpu2cc[ADR_WIDTH-1 -: TAG_W];
            req_idx  <= adr_cpu2cc[BYTE_OFF+WORD_OFF +: INDEX_W];
            req_woff <= adr_cpu2cc[BYTE_OFF +: WORD_OFF];
            req_wr   <= rdwr_cpu2cc;
          end
        end
        ST_LOOKUP: begin
          way_q <= hit ? hit_way : victim;
          cnt   <= '0;
        end
        ST_WRITEBACK: begin
          if (ack_mem2cc) cnt <= cnt + WORD_OFF'(1);
        end
        ST_REFILL: begin
          if (ack_mem2cc) begin
            data_mem[line_word_adr] <= dat_mem2cc;
            cnt                     <= cnt + WORD_OFF'(1);
            if (last_word) tag_mem[req_idx][way_q] <= '{valid: 1'b1, dirty: 1'b0, tag: req_tag};
          end
        end
        ST_HIT, ST_RESPOND: begin
          if (req_wr) begin
            data_mem[cpu_word_adr]        <= dat_cpu2cc;
            tag_mem[req_idx][way_q].dirty <= 1'b1;
          end
          age_mem[req_idx] <= next_ages;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_nway_wb.sv
// tb/tb_cache_nway_wb.sv - self-checking bench for cache_nway_wb with a word-wide memory model
module tb_cache_nway_wb;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_cpu2cc, rdwr_cpu2cc;
  logic [31:0] adr_cpu2cc, dat_cpu2cc;
  logic        ack_cc2cpu;
  logic [31:0] dat_cc2cpu;
  logic        req_cc2mem, rdwr_cc2mem;
  logic [31:0] adr_cc2mem, dat_cc2mem;
  logic        ack_mem2cc = 1'b0;
  logic [31:0] dat_mem2cc = 32'h0;
  logic        busy;

  cache_nway_wb #(
    .WORD_WIDTH(32), .ADR_WIDTH(32), .WAYS(4), .SETS(128), .WORDS_PER_LINE(4)
  ) dut (
    .clk(clk), .rst(rst),
    .req_cpu2cc(req_cpu2cc), .rdwr_cpu2cc(rdwr_cpu2cc),
    .adr_cpu2cc(adr_cpu2cc), .dat_cpu2cc(dat_cpu2cc),
    .ack_cc2cpu(ack_cc2cpu), .dat_cc2cpu(dat_cc2cpu),
    .req_cc2mem(req_cc2mem), .rdwr_cc2mem(rdwr_cc2mem),
    .adr_cc2mem(adr_cc2mem), .dat_cc2mem(dat_cc2mem),
    .ack_mem2cc(ack_mem2cc), .dat_mem2cc(dat_mem2cc),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    logic [31:0] adr;
    logic [31:0] dat;
  } mem_op_t;

  typedef struct {
    bit          wr;
    logic [31:0] adr;
    logic [31:0] dat;
    int          wb;
    int          rf;
    int          lat;
    logic [31:0] wb_base;
  } vec_t;

  mem_op_t     log_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] mem     [bit [31:0]];
  logic [31:0] ref_mem [bit [31:0]];
  int          checks = 0;
  int          failures = 0;
  int          mem_delay = 0;
  int          wait_cnt = 0;
  bit          hold_bad = 1'b0;
  logic [31:0] snap_adr, snap_dat;
  logic        snap_rdwr;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return init_word(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_word(a);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Memory responder: acks after mem_delay waiting cycles and watches that the request holds still.
  always @(negedge clk) begin
    if (req_cc2mem === 1'b1) begin
      if (wait_cnt == 0) begin
        snap_adr  = adr_cc2mem;
        snap_dat  = dat_cc2mem;
        snap_rdwr = rdwr_cc2mem;
        hold_bad  = 1'b0;
      end else if (adr_cc2mem !== snap_adr || dat_cc2mem !== snap_dat || rdwr_cc2mem !== snap_rdwr) begin
        hold_bad = 1'b1;
      end
      if (wait_cnt == mem_delay) begin
        if (mem_delay > 0) chk("mem_hold", {31'd0, hold_bad}, 32'd0);
        ack_mem2cc = 1'b1;
        if (rdwr_cc2mem) begin
          mem[adr_cc2mem] = dat_cc2mem;
          dat_mem2cc      = 32'h0;
          log_q.push_back('{1'b1, adr_cc2mem, dat_cc2mem});
        end else begin
          dat_mem2cc = mem_rd(adr_cc2mem);
          log_q.push_back('{1'b0, adr_cc2mem, dat_mem2cc});
        end
        wait_cnt = 0;
      end else begin
        ack_mem2cc = 1'b0;
        wait_cnt++;
      end
    end else begin
      ack_mem2cc = 1'b0;
      wait_cnt   = 0;
    end
  end

  task automatic do_req(input bit wr, input logic [31:0] a, input logic [31:0] d,
                        input int exp_wb, input int exp_rf, input int exp_lat,
                        input logic [31:0] wb_base, input string nm);
    int          lat;
    int          nwb;
    int          nrf;
    logic [31:0] got;
    log_q.delete();
    if (wr) ref_mem[a] = d;
    else    exp_q.push_back(ref_rd(a));
    req_cpu2cc  = 1'b1;
    rdwr_cpu2cc = wr;
    adr_cpu2cc  = a;
    dat_cpu2cc  = d;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (ack_cc2cpu !== 1'b1 && lat < 2000);
    if (ack_cc2cpu !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=no_ack required=ack", nm);
      req_cpu2cc = 1'b0;
      if (!wr) void'(exp_q.pop_front());
      return;
    end
    got = dat_cc2cpu;
    req_cpu2cc = 1'b0;
    if (!wr) chk({nm, "_data"}, got, exp_q.pop_front());
    if (exp_lat >= 0) chk({nm, "_latency"}, lat, exp_lat);
    nwb = 0;
    nrf = 0;
    foreach (log_q[j]) begin
      if (log_q[j].wr) nwb++;
      else             nrf++;
    end
    chk({nm, "_wb_count"}, nwb, exp_wb);
    chk({nm, "_rf_count"}, nrf, exp_rf);
    foreach (log_q[j]) begin
      if (log_q[j].wr) begin
        chk({nm, "_wb_adr"}, log_q[j].adr, wb_base + 32'(4 * j));
        chk({nm, "_wb_dat"}, log_q[j].dat, ref_rd(log_q[j].adr));
      end else begin
        chk({nm, "_rf_adr"}, log_q[j].adr, {a[31:4], 4'h0} + 32'(4 * (j - nwb)));
      end
    end
    @(posedge clk); #1;
    chk({nm, "_ack_pulse"}, {31'd0, ack_cc2cpu}, 32'd0);
  endtask

  initial begin
    vec_t tbl[$];
    int   n;
    rst = 1'b1;
    req_cpu2cc = 1'b0; rdwr_cpu2cc = 1'b0; adr_cpu2cc = 32'h0; dat_cpu2cc = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack",      {31'd0, ack_cc2cpu},  32'd0);
    chk("rst_req_mem",  {31'd0, req_cc2mem},  32'd0);
    chk("rst_rdwr_mem", {31'd0, rdwr_cc2mem}, 32'd0);
    chk("rst_dat_cpu",  dat_cc2cpu, 32'd0);
    chk("rst_adr_mem",  adr_cc2mem, 32'd0);
    chk("rst_dat_mem",  dat_cc2mem, 32'd0);
    chk("rst_busy",     {31'd0, busy}, 32'd1);
    rst = 1'b0;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (busy === 1'b1 && n < 1000);
    chk("init_cycles", n, 128);

    //             wr  adr           dat            wb rf lat wb_base
    tbl.push_back('{0, 32'h0000_0010, 32'h0,        0, 4, 6,  32'h0});
    tbl.push_back('{0, 32'h0000_0010, 32'h0,        0, 0, 2,  32'h0});
    tbl.push_back('{0, 32'h0000_001C, 32'h0,        0, 0, 2,  32'h0});
    tbl.push_back('{1, 32'h0000_0014, 32'hDEADBEEF, 0, 0, 2,  32'h0});
    tbl.push_back('{0, 32'h0000_0014, 32'h0,        0, 0, 2,  32'h0});
    tbl.push_back('{0, 32'h0000_0810, 32'h0,        0, 4, 6,  32'h0});
    tbl.push_back('{0, 32'h0000_1010, 32'h0,        0, 4, 6,  32'h0});
    tbl.push_back('{0, 32'h0000_1810, 32'h0,        0, 4, 6,  32'h0});
    tbl.push_back('{0, 32'h0000_2010, 32'h0,        4, 4, 10, 32'h10});
    tbl.push_back('{0, 32'h0000_0014, 32'h0,        0, 4, 6,  32'h0});
    tbl.push_back('{0, 32'h0000_0020, 32'h0,        0, 4, 6,  32'h0});
    tbl.push_back('{0, 32'h0000_0820, 32'h0,        0, 4, 6,  32'h0});
    tbl.push_back('{0, 32'h0000_1020, 32'h0,        0, 4, 6,  32'h0});
    tbl.push_back('{0, 32'h0000_1820, 32'h0,        0, 4, 6,  32'h0});
    tbl.push_back('{0, 32'h0000_0020, 32'h0,        0, 0, 2,  32'h0});
    tbl.push_back('{0, 32'h0000_2020, 32'h0,        0, 4, 6,  32'h0});
    tbl.push_back('{0, 32'h0000_0824, 32'h0,        0, 4, 6,  32'h0});
    tbl.push_back('{0, 32'h0000_0028, 32'h0,        0, 0, 2,  32'h0});
    tbl.push_back('{0, 32'h0000_182C, 32'h0,        0, 0, 2,  32'h0});
    tbl.push_back('{0, 32'h0000_1020, 32'h0,        0, 4, 6,  32'h0});
    tbl.push_back('{1, 32'h0000_3034, 32'hCAFEF00D, 0, 4, 6,  32'h0});
    tbl.push_back('{0, 32'h0000_3034, 32'h0,        0, 0, 2,  32'h0});
    tbl.push_back('{0, 32'h0000_3030, 32'h0,        0, 0, 2,  32'h0});
    foreach (tbl[i]) begin
      do_req(tbl[i].wr, tbl[i].adr, tbl[i].dat, tbl[i].wb, tbl[i].rf, tbl[i].lat,
             tbl[i].wb_base, $sformatf("v%0d", i));
    end

    mem_delay = 5;
    do_req(0, 32'h0000_4040, 32'h0, 0, 4, 26, 32'h0, "stall_miss");
    do_req(0, 32'h0000_4048, 32'h0, 0, 0, 2,  32'h0, "stall_hit");

    mem_delay = 2;
    log_q.delete();
    req_cpu2cc = 1'b1; rdwr_cpu2cc = 1'b0; adr_cpu2cc = 32'h0000_5050; dat_cpu2cc = 32'h0;
    n = 0;
    while (log_q.size() < 2 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (log_q.size() < 2) begin
      checks++;
      failures++;
      $display("FAIL midrefill_timeout actual=%0d required=2", log_q.size());
    end
    rst = 1'b1;
    req_cpu2cc = 1'b0;
    @(posedge clk); #1;
    chk("midrefill_req_drop", {31'd0, req_cc2mem}, 32'd0);
    chk("midrefill_busy",     {31'd0, busy},       32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    do_req(0, 32'h0000_5050, 32'h0, 0, 4, 142, 32'h0, "midrefill_reread");
    do_req(0, 32'h0000_5054, 32'h0, 0, 0, 2,   32'h0, "midrefill_hit");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
